// File: rtl/calc1_resp_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : calc1_resp_engine_if
//  Description : Request/response bundle for one calc1 responder port.
//                Bit 0 is the MSB of every vector.
//                master : drives req_cmd_in / req_data_in, observes responses
//                slave  : the responder engine
//  Ports       : req_cmd_in [0:3]   command code
//                req_data_in [0:31] operand1 (command beat) / operand2 (next beat)
//                out_resp [0:1]     0 none, 1 success, 2 error
//                out_data [0:31]    result, non-zero only on a success beat
//                busy               transaction in flight
//                cmd_dropped        sticky: command arrived while busy
//  Revision    : 1.0  initial release
// ============================================================================
interface calc1_resp_engine_if;
    logic [0:3]  req_cmd_in;
    logic [0:31] req_data_in;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        busy;
    logic        cmd_dropped;

    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, busy, cmd_dropped
    );

    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, busy, cmd_dropped
    );
endinterface
`default_nettype wire

// File: rtl/calc1_resp_engine.sv
`default_nettype none
// ============================================================================
//  Module      : calc1_resp_engine
//  Description : Single-port calc1 responder. Captures a two-beat command
//                (command + operand1, then operand2), executes add, subtract
//                or shift, and returns a one-cycle response LATENCY cycles
//                after the operand2 beat.
//  Ports       : c_clk  - clock, rising edge
//                reset  - synchronous active-high reset
//                bus    - calc1_resp_engine_if.slave (request/response bundle)
//  Parameters  : LATENCY - operand2 beat to response beat, 1..15
//  Revision    : 1.0  initial release
// ============================================================================
module calc1_resp_engine #(
    parameter int LATENCY = 3
) (
    input  logic                c_clk,
    input  logic                reset,
    calc1_resp_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [3:0] c_wait_load = 4'(LATENCY - 1);
    localparam logic [1:0] c_resp_ok   = 2'd1;
    localparam logic [1:0] c_resp_err  = 2'd2;

    state_t      state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic [0:3]  cmd_q,      cmd_d;
    logic [0:31] op1_q,      op1_d;
    logic [0:1]  res_resp_q, res_resp_d;
    logic [0:31] res_data_q, res_data_d;
    logic [0:1]  out_resp_q, out_resp_d;
    logic [0:31] out_data_q, out_data_d;
    logic        busy_q,     busy_d;
    logic        dropped_q,  dropped_d;

    logic [32:0] w_sum;
    logic [4:0]  w_shamt;
    logic [0:1]  w_resp;
    logic [0:31] w_data;
    logic        w_cmd_valid;

    assign w_cmd_valid = (bus.req_cmd_in != 4'd0);

    // Result of the captured command against the operand2 currently on the bus.
    always_comb begin
        w_sum   = {1'b0, op1_q} + {1'b0, bus.req_data_in};
        w_shamt = bus.req_data_in[27:31];
        w_resp  = c_resp_err;
        w_data  = '0;
        case (cmd_q)
            4'd1: begin
                if (!w_sum[32]) begin
                    w_resp = c_resp_ok;
                    w_data = w_sum[31:0];
                end
            end
            4'd2: begin
                if (bus.req_data_in <= op1_q) begin
                    w_resp = c_resp_ok;
                    w_data = op1_q - bus.req_data_in;
                end
            end
            4'd5: begin
                w_resp = c_resp_ok;
                w_data = op1_q << w_shamt;
            end
            4'd6: begin
                w_resp = c_resp_ok;
                w_data = op1_q >> w_shamt;
            end
            default: begin
                w_resp = c_resp_err;
                w_data = '0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        op1_d      = op1_q;
        res_resp_d = res_resp_q;
        res_data_d = res_data_q;
        out_resp_d = '0;
        out_data_d = '0;
        dropped_d  = dropped_q;
        case (state_q)
            ST_IDLE: begin
                if (w_cmd_valid) begin
                    cmd_d   = bus.req_cmd_in;
                    op1_d   = bus.req_data_in;
                    state_d = ST_OP2;
                end
            end
            ST_OP2: begin
                // The operand2 beat is consumed whatever req_cmd_in holds.
                res_resp_d = w_resp;
                res_data_d = w_data;
                cnt_d      = c_wait_load;
                state_d    = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (w_cmd_valid) dropped_d = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (w_cmd_valid) dropped_d = 1'b1;
                // Outputs are registered, so the response beat is the cycle
                // after RESP, by which time the FSM already accepts commands.
                out_resp_d = res_resp_q;
                out_data_d = res_data_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            op1_q      <= '0;
            res_resp_q <= '0;
            res_data_q <= '0;
            out_resp_q <= '0;
            out_data_q <= '0;
            busy_q     <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            op1_q      <= op1_d;
            res_resp_q <= res_resp_d;
            res_data_q <= res_data_d;
            out_resp_q <= out_resp_d;
            out_data_q <= out_data_d;
            busy_q     <= busy_d;
            dropped_q  <= dropped_d;
        end
    end

    assign bus.out_resp    = out_resp_q;
    assign bus.out_data    = out_data_q;
    assign bus.busy        = busy_q;
    assign bus.cmd_dropped = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_calc1_resp_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc1_resp_engine
//  Description : Self-checking bench for calc1_resp_engine. Three engines
//                with LATENCY 3, 1 and 15 share one stimulus stream; each is
//                compared every cycle against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_calc1_resp_engine;

    localparam int N = 3;
    int lat [N] = '{3, 1, 15};

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  cmd_drv;
    logic [31:0] data_drv;

    always #5 c_clk = ~c_clk;

    calc1_resp_engine_if if0 ();
    calc1_resp_engine_if if1 ();
    calc1_resp_engine_if if2 ();

    assign if0.req_cmd_in  = cmd_drv;
    assign if0.req_data_in = data_drv;
    assign if1.req_cmd_in  = cmd_drv;
    assign if1.req_data_in = data_drv;
    assign if2.req_cmd_in  = cmd_drv;
    assign if2.req_data_in = data_drv;

    calc1_resp_engine #(.LATENCY(3))  u_dut_l3  (.c_clk(c_clk), .reset(reset), .bus(if0));
    calc1_resp_engine #(.LATENCY(1))  u_dut_l1  (.c_clk(c_clk), .reset(reset), .bus(if1));
    calc1_resp_engine #(.LATENCY(15)) u_dut_l15 (.c_clk(c_clk), .reset(reset), .bus(if2));

    logic [1:0]  obs_resp [N];
    logic [31:0] obs_data [N];
    logic        obs_busy [N];
    logic        obs_drop [N];

    assign obs_resp[0] = if0.out_resp;
    assign obs_data[0] = if0.out_data;
    assign obs_busy[0] = if0.busy;
    assign obs_drop[0] = if0.cmd_dropped;
    assign obs_resp[1] = if1.out_resp;
    assign obs_data[1] = if1.out_data;
    assign obs_busy[1] = if1.busy;
    assign obs_drop[1] = if1.cmd_dropped;
    assign obs_resp[2] = if2.out_resp;
    assign obs_data[2] = if2.out_data;
    assign obs_busy[2] = if2.busy;
    assign obs_drop[2] = if2.cmd_dropped;

    // Reference model: one in-flight transaction per engine, tracked by the
    // number of edges since it was accepted.
    bit          m_act  [N] = '{default: 1'b0};
    int          m_age  [N] = '{default: 0};
    logic [3:0]  m_cmd  [N];
    logic [31:0] m_op1  [N];
    logic [1:0]  m_res  [N];
    logic [31:0] m_dat  [N];
    logic        m_drop [N] = '{default: 1'b0};
    logic [1:0]  e_resp [N] = '{default: 2'd0};
    logic [31:0] e_data [N] = '{default: 32'd0};
    logic        e_busy [N] = '{default: 1'b0};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    // Returns {resp, data}.
    function automatic logic [33:0] ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint unsigned s;
        case (c)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s > 64'h0000_0000_FFFF_FFFF) return {2'd2, 32'd0};
                return {2'd1, s[31:0]};
            end
            4'd2: begin
                if (b > a) return {2'd2, 32'd0};
                return {2'd1, a - b};
            end
            4'd5:    return {2'd1, a << (b % 32)};
            4'd6:    return {2'd1, a >> (b % 32)};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] c, input logic [31:0] d);
        for (int i = 0; i < N; i++) begin
            e_resp[i] = 2'd0;
            e_data[i] = 32'd0;
            if (r) begin
                m_act[i]  = 1'b0;
                m_drop[i] = 1'b0;
            end else if (!m_act[i]) begin
                if (c != 4'd0) begin
                    m_act[i] = 1'b1;
                    m_age[i] = 0;
                    m_cmd[i] = c;
                    m_op1[i] = d;
                end
            end else begin
                m_age[i]++;
                if (m_age[i] == 1) {m_res[i], m_dat[i]} = ref_op(m_cmd[i], m_op1[i], d);
                else if (c != 4'd0) m_drop[i] = 1'b1;
                if (m_age[i] == lat[i] + 1) begin
                    e_resp[i] = m_res[i];
                    e_data[i] = m_dat[i];
                    m_act[i]  = 1'b0;
                end
            end
            e_busy[i] = m_act[i];
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] c, input logic [31:0] d);
        reset    = r;
        cmd_drv  = c;
        data_drv = d;
        @(posedge c_clk);
        model_edge(r, c, d);
        #1;
        for (int i = 0; i < N; i++) begin
            check_value($sformatf("resp_L%0d", lat[i]), 32'(obs_resp[i]), 32'(e_resp[i]));
            check_value($sformatf("data_L%0d", lat[i]), obs_data[i], e_data[i]);
            check_value($sformatf("busy_L%0d", lat[i]), 32'(obs_busy[i]), 32'(e_busy[i]));
            check_value($sformatf("drop_L%0d", lat[i]), 32'(obs_drop[i]), 32'(m_drop[i]));
        end
    endtask

    task automatic txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        cycle(1'b0, c, a);
        cycle(1'b0, 4'd0, b);
        repeat (18) cycle(1'b0, 4'd0, $urandom);
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 40));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] pick_cmd();
        logic [3:0] valid_cmds [4] = '{4'd1, 4'd2, 4'd5, 4'd6};
        if ($urandom_range(0, 4) == 0) return 4'($urandom_range(1, 15));
        return valid_cmds[$urandom_range(0, 3)];
    endfunction

    initial begin
        repeat (4) cycle(1'b1, 4'd0, 32'd0);

        txn(4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
        txn(4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
        txn(4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
        txn(4'd2, 32'h0000_0001, 32'h0000_000F);
        txn(4'd2, 32'h0000_000F, 32'h0000_000F);
        txn(4'd5, 32'h0000_0001, 32'd31);
        txn(4'd6, 32'h8000_0000, 32'hFFFF_FFE0);
        txn(4'd3, 32'h0000_0001, 32'h0000_0001);
        txn(4'd4, 32'h0000_0001, 32'h0000_0001);

        // Second command while the first is still waiting.
        cycle(1'b0, 4'd1, 32'd5);
        cycle(1'b0, 4'd0, 32'd7);
        cycle(1'b0, 4'd0, 32'd0);
        cycle(1'b0, 4'd1, 32'd9);
        repeat (20) cycle(1'b0, 4'd0, 32'd3);

        // Reset in the middle of the wait: no response, drop flag cleared.
        cycle(1'b0, 4'd1, 32'd100);
        cycle(1'b0, 4'd0, 32'd200);
        cycle(1'b0, 4'd0, 32'd0);
        cycle(1'b1, 4'd0, 32'd0);
        repeat (20) cycle(1'b0, 4'd0, 32'd0);

        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 5) == 0) ? pick_cmd() : 4'd0,
                  pick_data());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
